// File: rtl/add_seq_arb_if.sv
// Handshake and shared-adder bundle for add_seq_arb.
// Ports: req/operand inputs, done/result outputs, adder slice drive and return.
// Optional ovf signal present only when ADD_SEQ_OVF_EN is defined.
interface add_seq_arb_if #(
   parameter int WORDS = 4
);
   logic                 req0;
   logic                 req1;
   logic [8*WORDS-1:0]   a0;
   logic [8*WORDS-1:0]   b0;
   logic [8*WORDS-1:0]   a1;
   logic [8*WORDS-1:0]   b1;
   logic                 done0;
   logic                 done1;
   logic [8*WORDS-1:0]   sum;
   logic                 cout;
   logic                 owner;
   logic                 busy;
   logic [7:0]           add_a;
   logic [7:0]           add_b;
   logic                 add_cin;
   logic [7:0]           add_sum;
   logic                 add_cout;
`ifdef ADD_SEQ_OVF_EN
   logic                 ovf;
`endif

   // Requester side plus the external adder slice.
   modport master (
`ifdef ADD_SEQ_OVF_EN
      input  ovf,
`endif
      output req0, req1,
      output a0, b0, a1, b1,
      output add_sum, add_cout,
      input  done0, done1,
      input  sum, cout, owner, busy,
      input  add_a, add_b, add_cin
   );

   // Arbiter/sequencer side.
   modport slave (
`ifdef ADD_SEQ_OVF_EN
      output ovf,
`endif
      input  req0, req1,
      input  a0, b0, a1, b1,
      input  add_sum, add_cout,
      output done0, done1,
      output sum, cout, owner, busy,
      output add_a, add_b, add_cin
   );
endinterface

// File: rtl/add_seq_arb.sv
// Two-requester round-robin arbiter driving a byte-serial adder through a
// shared external 8-bit adder slice; IDLE -> RUN (WORDS cycles) -> DONE.
// Ports: clk, rst (sync, active-high), bus (add_seq_arb_if.slave).
// Optional feature: define ADD_SEQ_OVF_EN for a registered signed-overflow
// flag (bus.ovf) updated with the result.
module add_seq_arb #(
   parameter int WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   add_seq_arb_if.slave  bus
);

   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef logic [WORDS-1:0][7:0] bytes_t;

   logic [1:0]     state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           gnt_q, gnt_d;
   logic           last_q, last_d;
   logic           carry_q, carry_d;
   bytes_t         opa_q, opa_d;
   bytes_t         opb_q, opb_d;
   bytes_t         res_q, res_d;
   logic [8*WORDS-1:0] sum_q, sum_d;
   logic           cout_q, cout_d;
   logic           owner_q, owner_d;
   logic           done0_q, done0_d;
   logic           done1_q, done1_d;
`ifdef ADD_SEQ_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   logic           any_req;
   logic           pick;
   logic           run;

   assign any_req = bus.req0 | bus.req1;

   // On a tie the requester not served last wins; last_q resets to 1
   // so requester 0 wins the first tie.
   assign pick = bus.req1 & (~bus.req0 | ~last_q);

   assign run = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      owner_d = owner_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d   = pick;
               opa_d   = pick ? bus.a1 : bus.a0;
               opb_d   = pick ? bus.b1 : bus.b0;
               idx_d   = '0;
               carry_d = 1'b0;
               state_d = RUN;
            end
         end

         RUN: begin
            res_d[idx_q] = bus.add_sum;
            carry_d      = bus.add_cout;
            if (idx_q == LAST) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            sum_d   = res_q;
            cout_d  = carry_q;
            owner_d = gnt_q;
            done0_d = ~gnt_q;
            done1_d = gnt_q;
            last_d  = gnt_q;
`ifdef ADD_SEQ_OVF_EN
            // Signed overflow: operands agree in sign, result does not.
            ovf_d = (opa_q[WORDS-1][7] == opb_q[WORDS-1][7]) &&
                    (res_q[WORDS-1][7] != opa_q[WORDS-1][7]);
`endif
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         owner_q <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         owner_q <= owner_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // The adder slice sees zeros whenever no byte is being processed.
   assign bus.add_a   = run ? opa_q[idx_q] : 8'h00;
   assign bus.add_b   = run ? opb_q[idx_q] : 8'h00;
   assign bus.add_cin = run ? carry_q : 1'b0;

   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;
   assign bus.owner = owner_q;
   assign bus.done0 = done0_q;
   assign bus.done1 = done1_q;
   assign bus.busy  = (state_q != IDLE);
`ifdef ADD_SEQ_OVF_EN
   assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_arb.sv
// Scoreboard bench for add_seq_arb: a transaction-level model predicts each
// grant and its completion edge; a negedge monitor checks every cycle.
module tb_add_seq_arb;

   localparam int W = 4;
   localparam int N = 8 * W;

   typedef struct {
      int             due;
      logic           own;
      logic [N-1:0]   s;
      logic           c;
      logic           v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   add_seq_arb_if #(.WORDS(W)) bus ();

   add_seq_arb #(.WORDS(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Shared combinational 8-bit adder slice.
   assign {bus.add_cout, bus.add_sum} =
      {1'b0, bus.add_a} + {1'b0, bus.add_b} + 9'(bus.add_cin);

   exp_t q[$];
   int   edge_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   // Reference model state.
   logic last_m = 1'b1;
   int   free_m = 0;
   int   blo = 0;
   int   bhi = -1;
   int   rst_at = -1;

   logic [N-1:0] cur_s = '0;
   logic         cur_c = 1'b0;
   logic         cur_o = 1'b0;
   logic         cur_v = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)",
                  nm, act, expv, edge_cnt);
      end
   endtask

   function automatic logic [N-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) r = '1;
      if ($urandom_range(0, 7) == 0) r = 64'h0;
      return r[N-1:0];
   endfunction

   // Drive one cycle of inputs (sampled at the next edge) and predict.
   task automatic step(input logic r, input logic r0, input logic r1,
                       input logic [N-1:0] x0, input logic [N-1:0] y0,
                       input logic [N-1:0] x1, input logic [N-1:0] y1);
      int e;
      logic g;
      logic [N:0] full;
      exp_t ex;
      @(posedge clk);
      #1;
      rst = r;
      bus.req0 = r0;
      bus.req1 = r1;
      bus.a0 = x0;
      bus.b0 = y0;
      bus.a1 = x1;
      bus.b1 = y1;
      e = edge_cnt + 1;
      if (r) begin
         last_m = 1'b1;
         free_m = 0;
         rst_at = e;
         if (bhi >= e) bhi = e - 1;
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due >= e) q.delete(i);
      end else if (e >= free_m && (r0 || r1)) begin
         g = (r0 && r1) ? !last_m : r1;
         if (g) full = {1'b0, x1} + {1'b0, y1};
         else   full = {1'b0, x0} + {1'b0, y0};
         ex.due = e + W + 1;
         ex.own = g;
         ex.s   = full[N-1:0];
         ex.c   = full[N];
         if (g) ex.v = (x1[N-1] == y1[N-1]) && (full[N-1] != x1[N-1]);
         else   ex.v = (x0[N-1] == y0[N-1]) && (full[N-1] != x0[N-1]);
         q.push_back(ex);
         last_m = g;
         free_m = e + W + 2;
         blo = e;
         bhi = e + W;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      int   k;
      logic eb;
      if (edge_cnt >= 2) begin
         k = edge_cnt;
         if (k == rst_at) begin
            cur_s = '0;
            cur_c = 1'b0;
            cur_o = 1'b0;
            cur_v = 1'b0;
         end
         if (q.size() > 0 && q[0].due == k) begin
            e = q.pop_front();
            chk("done0", 64'(bus.done0), 64'(!e.own));
            chk("done1", 64'(bus.done1), 64'(e.own));
            cur_s = e.s;
            cur_c = e.c;
            cur_o = e.own;
            cur_v = e.v;
         end else begin
            chk("spurious_done", 64'({bus.done0, bus.done1}), 64'h0);
         end
         chk("sum", 64'(bus.sum), 64'(cur_s));
         chk("cout", 64'(bus.cout), 64'(cur_c));
         chk("owner", 64'(bus.owner), 64'(cur_o));
`ifdef ADD_SEQ_OVF_EN
         chk("ovf", 64'(bus.ovf), 64'(cur_v));
`endif
         eb = (k >= blo) && (k <= bhi);
         chk("busy", 64'(bus.busy), 64'(eb));
         if (!eb)
            chk("adder_idle",
                64'({bus.add_a, bus.add_b, bus.add_cin}), 64'h0);
      end
   end

   initial begin
      int p;
      logic r0, r1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.a0 = '0;
      bus.b0 = '0;
      bus.a1 = '0;
      bus.b1 = '0;

      repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

      // Both requesters high from reset release; req0 wins the first tie.
      repeat (14)
         step(1'b0, 1'b1, 1'b1, 32'h12345678, 32'h11111111,
              32'h80000000, 32'h80000000);
      idle(W + 3);

      // Full carry ripple; a0 scrambled during RUN.
      step(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, rnd(), rnd());
      idle(W + 3);

      // Signed overflow case.
      step(1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001, rnd(), rnd());
      idle(W + 3);

      // req1 held continuously, req0 pulsed once.
      p = $urandom_range(3, 15);
      for (int i = 0; i < 30; i++)
         step(1'b0, (i == p), 1'b1, rnd(), rnd(), rnd(), rnd());
      idle(W + 3);

      // Random traffic with operands changing every cycle.
      for (int i = 0; i < 400; i++) begin
         r0 = ($urandom_range(0, 2) == 0);
         r1 = ($urandom_range(0, 2) == 0);
         step(1'b0, r0, r1, rnd(), rnd(), rnd(), rnd());
      end
      idle(W + 3);

      // Reset during RUN byte 2: no done, outputs back to reset values.
      step(1'b0, 1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
      idle(2);
      step(1'b1, 1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());
      idle(W + 4);

      // Tie after reset must go to req0 again.
      step(1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
      idle(W + 3);

      for (int i = 0; i < 100; i++) begin
         r0 = ($urandom_range(0, 1) == 0);
         r1 = ($urandom_range(0, 1) == 0);
         step(1'b0, r0, r1, rnd(), rnd(), rnd(), rnd());
      end
      idle(2 * W + 4);

      chk("queue_empty", 64'(q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/add_seq_arb.md
ADD_SEQ_ARB -- requirements
Module: add_seq_arb

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning the operand width in bytes (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: requester operation requests.
REQ-005 SHALL have ports a0, b0, a1 and b1, input, 8*WORDS bits each: per-requester operands.
REQ-006 SHALL have ports done0 and done1, output, 1 bit each: one-cycle completion pulses.
REQ-007 SHALL have port sum, output, 8*WORDS bits: registered result.
REQ-008 SHALL have port cout, output, 1 bit: registered carry-out.
REQ-009 SHALL have port owner, output, 1 bit: id of the requester whose result is on sum.
REQ-010 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.
REQ-011 SHALL have port add_a, output, 8 bits: operand byte to the shared adder slice.
REQ-012 SHALL have port add_b, output, 8 bits: operand byte to the shared adder slice.
REQ-013 SHALL have port add_cin, output, 1 bit: carry-in to the shared adder slice.
REQ-014 SHALL have port add_sum, input, 8 bits: sum from the shared combinational 8-bit adder slice.
REQ-015 SHALL have port add_cout, input, 1 bit: carry-out from the shared combinational 8-bit adder slice.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE: if req0 or req1 is sampled high, SHALL grant one requester, latch its a/b, set the byte index to 0, clear carry, and go to RUN; otherwise SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin via a last-served pointer: with both requests high, grant the requester not served last; with one request high, grant it.
REQ-019 RUN: each cycle SHALL drive add_a/add_b with latched byte[idx] and add_cin with the stored carry, then capture add_sum into result byte[idx] and add_cout into carry.
REQ-020 RUN SHALL last exactly WORDS cycles, LSB byte first; after the last byte SHALL go to DONE.
REQ-021 DONE (one cycle): SHALL update sum, cout and owner, pulse done of the granted requester, update the pointer, and return to IDLE.
REQ-022 Latency SHALL be: request sampled at edge T gives done high during cycle T+WORDS+1; minimum request-to-request spacing is WORDS+2 cycles.
REQ-023 Arithmetic SHALL be the unsigned 8*WORDS-bit sum modulo 2^(8*WORDS); cout is the final carry.
REQ-024 Operands SHALL be latched at grant; input changes after grant SHALL not affect the result.
REQ-025 A request dropped during RUN SHALL not abort the operation; done SHALL still pulse.
REQ-026 A request held high through DONE SHALL be re-arbitrated in the following IDLE cycle.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; no queueing.
REQ-028 Outside RUN, add_a, add_b and add_cin SHALL be 0.
REQ-029 sum, cout and owner SHALL hold their values until the next DONE.

Reset
REQ-030 rst at any edge, including mid-RUN, SHALL force IDLE, with sum=0, cout=0, owner=0, done0=done1=0, busy=0, add_*=0, carry=0, and the pointer set so req0 wins the first tie.
REQ-031 An operation interrupted by reset SHALL produce no done pulse.

Configuration
REQ-032 With macro ADD_SEQ_OVF_EN defined, SHALL add a registered 1-bit output ovf, updated at DONE, equal to signed overflow: both operand MSBs equal and sum MSB different; ovf resets to 0.
REQ-033 Without ADD_SEQ_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification (WORDS=4)
REQ-034 req0 with a0=0xFFFFFFFF, b0=0x00000001 SHALL give done0 five cycles after the grant edge, with sum=0x00000000, cout=1, owner=0.
REQ-035 req0 and req1 both high from reset release (a0+b0=0x12345678+0x11111111, a1+b1=0x80000000+0x80000000) SHALL give done0 first with sum=0x23456789, cout=0, then done1 six cycles later with sum=0x00000000, cout=1, owner=1.
REQ-036 req1 held high continuously with req0 pulsed once SHALL serve req0 at the next IDLE when req1 was served last, and the round-robin SHALL hold thereafter.
REQ-037 rst asserted during RUN byte 2 SHALL return all outputs to reset values on the next edge, with no done pulse.
REQ-038 With ADD_SEQ_OVF_EN, 0x7FFFFFFF+0x00000001 SHALL give ovf=1 and sum=0x80000000; 0xFFFFFFFF+0x00000001 SHALL give ovf=0.
REQ-039 a0 changed mid-RUN SHALL leave the result unchanged from the latched operands.
